pwm_switch_driver_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-channel photonic-switch PWM driver.
- Each of NCH channels produces a complementary drive pair (signal / signal_b) with a programmable period, high time and dead time.
- During the dead time both outputs are low (latch state).
- Runs entirely in the core clock domain, advanced by a tick enable. Channel settings are written over a simple load/ack port from the decoder/control logic.

---
 rtl/pwm_switch_driver_multi.sv | 178 +++++++++++++++++
 tb/tb_pwm_switch_driver_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_switch_driver_multi.sv
// Multi-channel complementary PWM driver with per-channel period, high time and dead time.
// Latency: load_ack/load_err one cycle after load; outputs registered, same edge as counter.
// Backpressure: none; every load is accepted (or rejected with load_err) the cycle it arrives.
//
// Ports:
//   clk, reset          core clock, asynchronous active-high reset
//   en                  tick enable; counters and dead timers advance only when set
//   load, ch_sel        write strobe and channel index for {period, high, dead}
//   load_ack, load_err  one-cycle response pulses for a load
//   signal, signal_b    complementary drive pair per channel
//   latch               per channel, both drive outputs low
//   period_start        one-cycle pulse when a channel counter wraps to 0
//
// Optional feature macro: PWMSW_SHADOW_EN
//   defined   : loads go to a shadow register, copied to the active set at the
//               period wrap (or at once if the channel is disabled)
//   undefined : loads write the active set directly and restart the channel
module pwm_switch_driver_multi #(
  parameter int NCH = 2,
  parameter int CW  = 13,
  parameter int DTW = 4,
  parameter int SW  = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           load,
  input  logic [SW-1:0]  ch_sel,
  input  logic [CW-1:0]  period,
  input  logic [CW-1:0]  high,
  input  logic [DTW-1:0] dead,
  output logic           load_ack,
  output logic           load_err,
  output logic [NCH-1:0] signal,
  output logic [NCH-1:0] signal_b,
  output logic [NCH-1:0] latch,
  output logic [NCH-1:0] period_start
);

  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [DTW-1:0] DT_ONE  = DTW'(1);

  logic sel_bad;
  assign sel_bad = 32'(ch_sel) >= 32'(NCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_ack <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_ack <= load && !sel_bad;
      load_err <= load && sel_bad;
    end
  end

  assign latch = ~signal & ~signal_b;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0]  period_q, high_q, cnt_q;
    logic [DTW-1:0] dead_q, dtc_q;
    logic           raw_q, sig_q, sigb_q, ps_q;

    logic [CW-1:0]  period_n, high_n, cnt_n;
    logic [DTW-1:0] dead_n, dtc_n;
    logic           raw_n, sig_n, sigb_n, ps_n;
    logic           hit, active, wrap, start, start_ps;

`ifdef PWMSW_SHADOW_EN
    logic [CW-1:0]  period_s, high_s, period_sn, high_sn;
    logic [DTW-1:0] dead_s, dead_sn;
`endif

    assign hit = load && (ch_sel == SW'(i));

    always_comb begin
      active   = (period_q != '0);
      wrap     = active && en && (cnt_q == period_q - CNT_ONE);
      period_n = period_q;
      high_n   = high_q;
      dead_n   = dead_q;
      start    = 1'b0;
      start_ps = 1'b0;
`ifdef PWMSW_SHADOW_EN
      // Write-through: a load on the wrap cycle is what gets copied at that wrap.
      period_sn = period_s;
      high_sn   = high_s;
      dead_sn   = dead_s;
      if (hit) begin
        period_sn = period;
        high_sn   = high;
        dead_sn   = dead;
      end
      if (!active || wrap) begin
        period_n = period_sn;
        high_n   = high_sn;
        dead_n   = dead_sn;
      end
      // A disabled channel picking up a nonzero period starts at cnt=0 without a pulse.
      start = !active && (period_sn != '0);
`else
      if (hit) begin
        period_n = period;
        high_n   = high;
        dead_n   = dead;
        start    = (period != '0);
        start_ps = (period != '0);
      end
`endif

      cnt_n = cnt_q;
      dtc_n = dtc_q;
      raw_n = raw_q;
      ps_n  = 1'b0;
      if (period_n == '0) begin
        cnt_n = '0;
        dtc_n = '0;
        raw_n = 1'b0;
      end else if (start) begin
        // Fresh start always opens with a full dead interval, whatever the raw level.
        cnt_n = '0;
        raw_n = (high_n != '0);
        dtc_n = dead_n;
        ps_n  = start_ps;
      end else if (en) begin
        cnt_n = wrap ? '0 : cnt_q + CNT_ONE;
        ps_n  = wrap;
        raw_n = (cnt_n < high_n);
        if (raw_n != raw_q) begin
          dtc_n = dead_n;
        end else if (dtc_q != '0) begin
          dtc_n = dtc_q - DT_ONE;
        end
      end

      sig_n  = (period_n != '0) && (dtc_n == '0) && raw_n;
      sigb_n = (period_n != '0) && (dtc_n == '0) && !raw_n;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        period_q <= '0;
        high_q   <= '0;
        dead_q   <= '0;
        cnt_q    <= '0;
        dtc_q    <= '0;
        raw_q    <= 1'b0;
        sig_q    <= 1'b0;
        sigb_q   <= 1'b0;
        ps_q     <= 1'b0;
`ifdef PWMSW_SHADOW_EN
        period_s <= '0;
        high_s   <= '0;
        dead_s   <= '0;
`endif
      end else begin
        period_q <= period_n;
        high_q   <= high_n;
        dead_q   <= dead_n;
        cnt_q    <= cnt_n;
        dtc_q    <= dtc_n;
        raw_q    <= raw_n;
        sig_q    <= sig_n;
        sigb_q   <= sigb_n;
        ps_q     <= ps_n;
`ifdef PWMSW_SHADOW_EN
        period_s <= period_sn;
        high_s   <= high_sn;
        dead_s   <= dead_sn;
`endif
      end
    end

    assign signal[i]       = sig_q;
    assign signal_b[i]     = sigb_q;
    assign period_start[i] = ps_q;
  end

endmodule

// File: tb/tb_pwm_switch_driver_multi.sv
// Directed bench for pwm_switch_driver_multi (NCH=2, SW=2 so ch_sel=3 is out of range).
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_pwm_switch_driver_multi;
  localparam int NCH = 2;
  localparam int CW  = 13;
  localparam int DTW = 4;
  localparam int SW  = 2;
`ifdef PWMSW_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           load;
  logic [SW-1:0]  ch_sel;
  logic [CW-1:0]  period;
  logic [CW-1:0]  high;
  logic [DTW-1:0] dead;
  logic           load_ack;
  logic           load_err;
  logic [NCH-1:0] signal;
  logic [NCH-1:0] signal_b;
  logic [NCH-1:0] latch;
  logic [NCH-1:0] period_start;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_switch_driver_multi #(.NCH(NCH), .CW(CW), .DTW(DTW), .SW(SW)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .ch_sel(ch_sel),
    .period(period), .high(high), .dead(dead), .load_ack(load_ack),
    .load_err(load_err), .signal(signal), .signal_b(signal_b),
    .latch(latch), .period_start(period_start)
  );

  typedef struct {
    bit ld; int sel; int per; int hi; int dd; bit e;
    int sig; int sigb; int ps; bit ack; bit err;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit ld, input int sel, input int per, input int hi,
                              input int dd, input bit e, input int sig, input int sigb,
                              input int ps, input bit ack, input bit err);
    vec_t v;
    v = '{ld, sel, per, hi, dd, e, sig, sigb, ps, ack, err};
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input int es, input int esb, input int eps,
                          input bit eack, input bit eerr);
    chk({name, ".signal"}, int'(signal), es);
    chk({name, ".signal_b"}, int'(signal_b), esb);
    chk({name, ".latch"}, int'(latch), (~(es | esb)) & 3);
    chk({name, ".period_start"}, int'(period_start), eps);
    chk({name, ".load_ack"}, int'(load_ack), int'(eack));
    chk({name, ".load_err"}, int'(load_err), int'(eerr));
  endtask

  task automatic drive(input bit ld, input int sel, input int per, input int hi,
                       input int dd, input bit e);
    load   = ld;
    ch_sel = SW'(sel);
    period = CW'(per);
    high   = CW'(hi);
    dead   = DTW'(dd);
    en     = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    chk_outs(name, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    int s, sb, ps, c, off;
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Main table: ch0 {10,4,1}, out-of-range load, en hold.
    add(0, 0, 0,  0, 0, 1, 0, 0, 0,           0, 0);
    add(1, 0, 10, 4, 1, 1, 0, 0, SH ? 0 : 1,  1, 0);
    add(0, 0, 0,  0, 0, 1, 1, 0, 0,           0, 0);
    add(0, 0, 0,  0, 0, 1, 1, 0, 0,           0, 0);
    add(0, 0, 0,  0, 0, 1, 1, 0, 0,           0, 0);
    add(0, 0, 0,  0, 0, 1, 0, 0, 0,           0, 0);
    for (int j = 0; j < 5; j++) add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 1, 0, 0, 1,           0, 0);
    add(0, 0, 0,  0, 0, 1, 1, 0, 0,           0, 0);
    add(1, 3, 5,  1, 0, 1, 1, 0, 0,           0, 1);
    add(0, 0, 0,  0, 0, 1, 1, 0, 0,           0, 0);
    add(0, 0, 0,  0, 0, 0, 1, 0, 0,           0, 0);
    add(0, 0, 0,  0, 0, 0, 1, 0, 0,           0, 0);
    add(0, 0, 0,  0, 0, 1, 0, 0, 0,           0, 0);
    add(0, 0, 0,  0, 0, 1, 0, 1, 0,           0, 0);

    do_reset("reset0");
    foreach (tbl[r]) begin
      drive(tbl[r].ld, tbl[r].sel, tbl[r].per, tbl[r].hi, tbl[r].dd, tbl[r].e);
      tick();
      chk_outs($sformatf("tbl%0d", r), tbl[r].sig, tbl[r].sigb, tbl[r].ps,
               tbl[r].ack, tbl[r].err);
    end

    // ch1 high=0 then high=period: never both high.
    do_reset("reset1");
    drive(1, 1, 8, 0, 0, 1);
    tick();
    chk_outs("s1_load", 0, 2, SH ? 0 : 2, 1, 0);
    for (int j = 0; j < 3; j++) begin
      drive(0, 0, 0, 0, 0, 1);
      tick();
      chk_outs($sformatf("s1_pre%0d", j), 0, 2, 0, 0, 0);
    end
    for (int k = 0; k < 20; k++) begin
      if (k == 0) drive(1, 1, 8, 8, 0, 1); else drive(0, 0, 0, 0, 0, 1);
      tick();
      if (SH) begin
        s  = (k >= 4) ? 2 : 0;
        ps = (k == 4 || k == 12) ? 2 : 0;
      end else begin
        s  = 2;
        ps = (k % 8 == 0) ? 2 : 0;
      end
      sb = (s != 0) ? 0 : 2;
      chk_outs($sformatf("s1_k%0d", k), s, sb, ps, k == 0, 0);
      chk($sformatf("s1_overlap%0d", k), int'(signal & signal_b), 0);
    end

    // Mid-period reload of ch0 at cnt=3.
    do_reset("reset2");
    drive(1, 0, 10, 4, 0, 1);
    tick();
    chk_outs("s2_load", 1, 0, SH ? 0 : 1, 1, 0);
    for (int j = 0; j < 3; j++) begin
      drive(0, 0, 0, 0, 0, 1);
      tick();
      chk_outs($sformatf("s2_pre%0d", j), 1, 0, 0, 0, 0);
    end
    off = SH ? 6 : 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 0) drive(1, 0, 6, 2, 0, 1); else drive(0, 0, 0, 0, 0, 1);
      tick();
      if (k < off) begin
        s  = 0;
        ps = 0;
      end else begin
        c  = (k - off) % 6;
        s  = (c < 2) ? 1 : 0;
        ps = (c == 0) ? 1 : 0;
      end
      chk_outs($sformatf("s2_k%0d", k), s, 1 - s, ps, k == 0, 0);
    end

    // Load landing on the wrap cycle takes effect at that wrap.
    do_reset("reset3");
    drive(1, 0, 5, 2, 0, 1);
    tick();
    chk_outs("s3_load", 1, 0, SH ? 0 : 1, 1, 0);
    for (int j = 1; j <= 4; j++) begin
      drive(0, 0, 0, 0, 0, 1);
      tick();
      s = (j < 2) ? 1 : 0;
      chk_outs($sformatf("s3_pre%0d", j), s, 1 - s, 0, 0, 0);
    end
    for (int k = 0; k < 9; k++) begin
      if (k == 0) drive(1, 0, 4, 1, 0, 1); else drive(0, 0, 0, 0, 0, 1);
      tick();
      c = k % 4;
      s = (c < 1) ? 1 : 0;
      chk_outs($sformatf("s3_k%0d", k), s, 1 - s, (c == 0) ? 1 : 0, k == 0, 0);
    end

    // en asserted 1 cycle in 4, period 5: period_start every 20 clocks.
    do_reset("reset4");
    drive(1, 0, 5, 2, 0, 0);
    tick();
    chk("s4_ack", int'(load_ack), 1);
    for (int k = 0; k < 60; k++) begin
      drive(0, 0, 0, 0, 0, (k % 4) == 0);
      tick();
      ps = ((k % 4 == 0) && (((k / 4) + 1) % 5 == 0)) ? 1 : 0;
      chk($sformatf("s4_ps%0d", k), int'(period_start), ps);
    end

    // Asynchronous reset mid-period; settings do not survive.
    do_reset("reset5");
    drive(1, 0, 10, 4, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("s5_pre_sig", int'(signal), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_outs("s5_async", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_outs($sformatf("s5_post%0d", k), 0, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
